mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

MEM-stage data-memory controller: consumes the EX/MEM pipeline register outputs (ALU result as address, Val_Rm as store data, MEM_R_EN/MEM_W_EN) and performs the 32-bit load or store against the 16-bit external SRAM as two half-word accesses with programmable wait states. While an access is in flight it deasserts Ready, which the hazard/freeze logic uses to stall every pipeline register, including the EX/MEM register feeding this block. Load data goes to the MEM/WB register.

## Interface
- WAIT_CYCLES, 2: cycles each 16-bit SRAM access is held (≥1).
- ADDR_BASE, 1024: byte address subtracted from Address before SRAM mapping.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- RD_EN  in  1  load request (MEM_R_EN from EX/MEM).
- WR_EN  in  1  store request (MEM_W_EN from EX/MEM).
- Address  in  32  byte address (ALU result); word-aligned.
- WriteData  in  32  store data (Val_Rm).
- ReadData  out  32  registered load result.
- Ready  out  1  1 = no access pending; pipeline may advance.
- SRAM_ADDR  out  18  half-word address.
- SRAM_DQ_Out  out  16  write data to SRAM pad.
- SRAM_DQ_In  in  16  read data from SRAM pad.
- SRAM_DQ_OE  out  1  pad drive enable (1 only during write phases).
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes.

## Operation
- States: IDLE, LO, HI, DONE. Request req = RD_EN | WR_EN; WR_EN wins if both asserted (illegal, but defined).
- IDLE: strobes inactive (all _N = 1, DQ_OE = 0). If req: latch op (read/write), go LO, clear wait counter.
- LO: SRAM_ADDR = {w[16:0],1'b0}, where w = (Address − ADDR_BASE)[31:2] (modulo 2^32, upper bits dropped). Write: DQ_Out = WriteData[15:0], WE_N = 0, DQ_OE = 1. Read: OE_N = 0. CE_N = UB_N = LB_N = 0. Stay WAIT_CYCLES cycles; on last cycle a read captures SRAM_DQ_In into ReadData[15:0]; go HI.
- HI: same with SRAM_ADDR = {w[16:0],1'b1}, data = WriteData[31:16] / capture into ReadData[31:16]; after WAIT_CYCLES go DONE.
- DONE: strobes inactive, Ready = 1 for exactly one cycle; always go IDLE next.
- Ready (combinational) = (IDLE & ~req) | DONE.
- ReadData updated only by reads; holds across writes and idle.
- Address/WriteData are held stable by the frozen pipeline; the block samples them every access cycle and does not latch them.

## Timing
- Reset values: state IDLE, counter 0, ReadData 0, strobes inactive, DQ_OE 0, SRAM_ADDR 0, DQ_Out 0; Ready = ~req.
- Latency: request seen in IDLE at cycle 0 → Ready high in cycle 2·WAIT_CYCLES+1 (DONE); default 5 cycles stalled, released on 6th.
- ReadData valid from the cycle after the HI capture edge, i.e. throughout DONE.
- Back-to-back: after DONE the pipeline has advanced; a new req in the following IDLE cycle starts immediately (one idle cycle between accesses, Ready low in it if req).
- RST mid-access: next cycle IDLE, strobes released, partial ReadData cleared to 0; no DONE pulse.
- Deassertion of req mid-access (should not occur) does not abort; sequence completes.

## Structure
- Shared package: state enum (IDLE/LO/HI/DONE), SRAM_AW = 18, SRAM_DW = 16, default ADDR_BASE.
- Sub-module sram_wait_counter: clear/enable, terminal-count output at WAIT_CYCLES−1; width $clog2(WAIT_CYCLES+1).
- ReadData halves held with existing Register #(16) instances, ld = capture strobe.

## Test plan
- Reset: RST=1 two cycles with RD_EN=1 → ReadData=0, all _N=1, Ready=0 after release until DONE.
- Store Address=1028, WriteData=0xDEADBEEF → SRAM_ADDR 2 with DQ_Out 0xBEEF, WE_N=0 for 2 cycles, then 3 with 0xDEAD; Ready high in cycle 5.
- Load Address=1028 with model returning stored halves → ReadData=0xDEADBEEF in DONE, OE_N=0 and DQ_OE=0 throughout.
- Back-to-back store then load, same address → second access starts the cycle after DONE, read returns stored word.
- RST asserted in cycle 3 of a load → IDLE next cycle, ReadData=0, no Ready pulse from DONE.
- WAIT_CYCLES=1, Address=1024 load → SRAM_ADDR 0 then 1, Ready high in cycle 3.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// rtl/mem_sram_ctrl_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package mem_sram_ctrl_pkg;

    localparam int SRAM_AW           = 18;
    localparam int SRAM_DW           = 16;
    localparam int DEFAULT_ADDR_BASE = 1024;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/Register.sv
// rtl/Register.sv - loadable register with synchronous active-high clear
module Register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (ld) begin
            out <= in;
        end
    end

endmodule

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-access wait-state counter, wraps to zero on terminal count
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(WAIT_CYCLES - 1));

    // Wrapping on tc lets the HI half reuse the counter without an explicit clear.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - 32-bit load/store over a 16-bit SRAM as two wait-stated half-word accesses
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = DEFAULT_ADDR_BASE
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RD_EN,
    input  logic               WR_EN,
    input  logic [31:0]        Address,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    output logic               Ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_Out,
    input  logic [SRAM_DW-1:0] SRAM_DQ_In,
    output logic               SRAM_DQ_OE,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    state_t             state;
    state_t             state_nxt;
    logic               op_wr;
    logic               req;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic               ld_lo;
    logic               ld_hi;
    logic [16:0]        word_idx;
    logic [SRAM_DW-1:0] rd_lo;
    logic [SRAM_DW-1:0] rd_hi;

    assign req      = RD_EN | WR_EN;
    assign word_idx = 17'((Address - 32'(ADDR_BASE)) >> 2);
    assign ReadData = {rd_hi, rd_lo};
    assign Ready    = ((state == S_IDLE) && !req) || (state == S_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            op_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            // Write takes priority when both enables are raised.
            if (state == S_IDLE && req) begin
                op_wr <= WR_EN;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        SRAM_ADDR   = '0;
        SRAM_DQ_Out = '0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_CE_N   = 1'b1;
        SRAM_UB_N   = 1'b1;
        SRAM_LB_N   = 1'b1;
        cnt_clr     = 1'b1;
        cnt_en      = 1'b0;
        ld_lo       = 1'b0;
        ld_hi       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_LO;
                end
            end
            S_LO, S_HI: begin
                cnt_clr     = 1'b0;
                cnt_en      = 1'b1;
                SRAM_CE_N   = 1'b0;
                SRAM_UB_N   = 1'b0;
                SRAM_LB_N   = 1'b0;
                SRAM_ADDR   = {word_idx, (state == S_HI)};
                if (op_wr) begin
                    SRAM_DQ_Out = (state == S_HI) ? WriteData[31:16] : WriteData[15:0];
                    SRAM_DQ_OE  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end else begin
                    SRAM_OE_N   = 1'b0;
                end
                if (cnt_tc) begin
                    state_nxt = (state == S_HI) ? S_DONE : S_HI;
                    ld_lo     = !op_wr && (state == S_LO);
                    ld_hi     = !op_wr && (state == S_HI);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk(CLK),
        .rst(RST),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (cnt_tc)
    );

    Register #(.WIDTH(SRAM_DW)) u_rd_lo (
        .clk(CLK),
        .rst(RST),
        .ld (ld_lo),
        .in (SRAM_DQ_In),
        .out(rd_lo)
    );

    Register #(.WIDTH(SRAM_DW)) u_rd_hi (
        .clk(CLK),
        .rst(RST),
        .ld (ld_hi),
        .in (SRAM_DQ_In),
        .out(rd_hi)
    );

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - directed scoreboard bench for mem_sram_ctrl
module tb_mem_sram_ctrl;

    localparam int WC = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RD_EN, WR_EN;
    logic [31:0] Address, WriteData, ReadData;
    logic        Ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_Out;
    logic [15:0] SRAM_DQ_In = 16'h0;
    logic        SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    logic        RD_EN2, WR_EN2;
    logic [31:0] Address2, WriteData2, ReadData2;
    logic        Ready2;
    logic [17:0] SRAM_ADDR2;
    logic [15:0] SRAM_DQ_Out2;
    logic [15:0] SRAM_DQ_In2 = 16'h0;
    logic        SRAM_DQ_OE2, SRAM_WE_N2, SRAM_OE_N2, SRAM_CE_N2, SRAM_UB_N2, SRAM_LB_N2;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    logic [31:0] stored[int];
    logic [15:0] wmem[int];
    logic [31:0] last_rd;

    always #5 CLK = ~CLK;

    mem_sram_ctrl #(.WAIT_CYCLES(WC), .ADDR_BASE(1024)) dut (
        .CLK(CLK), .RST(RST), .RD_EN(RD_EN), .WR_EN(WR_EN),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Ready(Ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_Out(SRAM_DQ_Out), .SRAM_DQ_In(SRAM_DQ_In),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) dut1 (
        .CLK(CLK), .RST(RST), .RD_EN(RD_EN2), .WR_EN(WR_EN2),
        .Address(Address2), .WriteData(WriteData2), .ReadData(ReadData2), .Ready(Ready2),
        .SRAM_ADDR(SRAM_ADDR2), .SRAM_DQ_Out(SRAM_DQ_Out2), .SRAM_DQ_In(SRAM_DQ_In2),
        .SRAM_DQ_OE(SRAM_DQ_OE2), .SRAM_WE_N(SRAM_WE_N2), .SRAM_OE_N(SRAM_OE_N2),
        .SRAM_CE_N(SRAM_CE_N2), .SRAM_UB_N(SRAM_UB_N2), .SRAM_LB_N(SRAM_LB_N2)
    );

    function automatic logic [15:0] dflt_half(input logic [17:0] a);
        return 16'hA000 + 16'(a[11:0]);
    endfunction

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        return dflt_half(a);
    endfunction

    // SRAM models: writes land and read data is presented mid-cycle, away from the DUT's edge.
    always @(negedge CLK) begin
        if (!SRAM_CE_N && !SRAM_WE_N) wmem[int'(SRAM_ADDR)] = SRAM_DQ_Out;
        SRAM_DQ_In  = sram_rd(SRAM_ADDR);
        SRAM_DQ_In2 = dflt_half(SRAM_ADDR2);
    end

    function automatic logic [16:0] widx(input logic [31:0] addr);
        logic [31:0] d;
        d = (addr - 32'd1024) >> 2;
        return d[16:0];
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        logic [16:0] w;
        if (stored.exists(int'(addr))) return stored[int'(addr)];
        w = widx(addr);
        return {dflt_half({w, 1'b1}), dflt_half({w, 1'b0})};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the DONE cycle with requests dropped.
    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [16:0] w;
        logic [31:0] e;
        bit          hi;
        w = widx(addr);
        RD_EN = !wr; WR_EN = wr; Address = addr; WriteData = data;
        if (wr) stored[int'(addr)] = data;
        else    sb_q.push_back(exp_word(addr));
        #1;
        chk("idle_req_ready", {31'd0, Ready}, 32'd0);
        for (int c = 1; c <= 2 * WC; c++) begin
            tick();
            hi = (c > WC);
            chk("acc_addr",  {14'd0, SRAM_ADDR}, {14'd0, w, hi});
            chk("acc_we_n",  {31'd0, SRAM_WE_N}, {31'd0, !wr});
            chk("acc_oe_n",  {31'd0, SRAM_OE_N}, {31'd0, wr});
            chk("acc_dq_oe", {31'd0, SRAM_DQ_OE}, {31'd0, wr});
            chk("acc_ce_ub_lb", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
            chk("acc_ready", {31'd0, Ready}, 32'd0);
            if (wr) chk("acc_dq_out", {16'd0, SRAM_DQ_Out}, {16'd0, hi ? data[31:16] : data[15:0]});
        end
        tick();
        chk("done_ready", {31'd0, Ready}, 32'd1);
        chk("done_strobes", {29'd0, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N}, 32'd7);
        if (!wr) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("load_data", ReadData, e);
                last_rd = e;
            end
        end else begin
            chk("store_holds_rd", ReadData, last_rd);
        end
        RD_EN = 1'b0; WR_EN = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RD_EN = 1'b1; WR_EN = 1'b0; Address = 32'd1032; WriteData = '0;
        RD_EN2 = 1'b0; WR_EN2 = 1'b0; Address2 = '0; WriteData2 = '0;
        last_rd = '0;
        tick();
        tick();
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_strobes", {26'd0, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE}, 32'h3E);
        chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        chk("rst_dq_out", {16'd0, SRAM_DQ_Out}, 32'd0);
        chk("rst_ready_req", {31'd0, Ready}, 32'd0);
        RST = 1'b0;

        do_access(1'b0, 32'd1032, 32'd0);
        tick();
        do_access(1'b1, 32'd1028, 32'hDEADBEEF);
        tick();
        do_access(1'b0, 32'd1028, 32'd0);
        tick();
        do_access(1'b1, 32'd1036, 32'h12345678);
        tick();
        do_access(1'b0, 32'd1036, 32'd0);
        tick();
        chk("idle_ready", {31'd0, Ready}, 32'd1);
        chk("idle_holds_rd", ReadData, 32'h12345678);

        // Reset lands in the first HI cycle of a load.
        RD_EN = 1'b1; Address = 32'd1028;
        tick(); tick(); tick();
        chk("pre_rst_hi_addr", {14'd0, SRAM_ADDR}, 32'd3);
        RST = 1'b1;
        tick();
        RST = 1'b0; RD_EN = 1'b0;
        #1;
        chk("midrst_readdata", ReadData, 32'd0);
        chk("midrst_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        chk("midrst_ready_idle", {31'd0, Ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_quiet", {30'd0, SRAM_CE_N, SRAM_OE_N}, 32'd3);
            chk("midrst_rd_stays0", ReadData, 32'd0);
        end

        // Single wait state instance: load at the base address.
        RD_EN2 = 1'b1; Address2 = 32'd1024;
        #1;
        chk("w1_c0_ready", {31'd0, Ready2}, 32'd0);
        tick();
        chk("w1_c1_addr", {14'd0, SRAM_ADDR2}, 32'd0);
        chk("w1_c1_oe_n", {31'd0, SRAM_OE_N2}, 32'd0);
        chk("w1_c1_ready", {31'd0, Ready2}, 32'd0);
        tick();
        chk("w1_c2_addr", {14'd0, SRAM_ADDR2}, 32'd1);
        chk("w1_c2_ready", {31'd0, Ready2}, 32'd0);
        tick();
        chk("w1_c3_ready", {31'd0, Ready2}, 32'd1);
        chk("w1_c3_data", ReadData2, {16'hA001, 16'hA000});
        RD_EN2 = 1'b0;
        tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
